// File: rtl/pc_gen.sv
// Program-counter generator: fetch handshake, stall, redirect, trap/mret via EPC, halt mode, fetch counter.
// Optional macro PC_GEN_COMPRESSED_EN adds is_compressed (2-byte step, 2-byte target alignment).
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             mret,
    input  logic             halt_req,
`ifdef PC_GEN_COMPRESSED_EN
    input  logic             is_compressed,
`endif
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  epc_out,
    output logic             misaligned,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state;
    logic            accept;
    logic            tgt_misaligned;
    logic            redirect_trap;
    logic            flush;
    logic            count_en;
    logic [XLEN-1:0] step;

    always_comb begin
        accept = (state == RUN) && fetch_valid && fetch_ready && !stall;
`ifdef PC_GEN_COMPRESSED_EN
        tgt_misaligned = redirect_target[0];
        step           = is_compressed ? XLEN'(2) : XLEN'(4);
`else
        tgt_misaligned = |redirect_target[1:0];
        step           = XLEN'(4);
`endif
        // A misaligned redirect only becomes a trap when nothing of higher priority wins.
        redirect_trap = redirect_valid && tgt_misaligned && !trap_valid && !mret;
        flush         = trap_valid || mret || redirect_valid;
        count_en      = accept && !trap_valid && !redirect_trap;
    end

    assign pc_plus4 = pc_out + XLEN'(4);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= BOOT;
            pc_out      <= RESET_VECTOR;
            epc_out     <= '0;
            instr_count <= '0;
            misaligned  <= 1'b0;
            halted      <= 1'b0;
            fetch_valid <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    halted      <= 1'b0;
                end
                RUN: begin
                    if (trap_valid || redirect_trap) begin
                        pc_out  <= TRAP_VECTOR;
                        epc_out <= pc_out;
                    end else if (mret) begin
                        pc_out <= epc_out;
                    end else if (redirect_valid) begin
                        pc_out <= redirect_target;
                    end else if (accept) begin
                        pc_out <= pc_out + step;
                    end
                    misaligned <= redirect_trap;
                    if (count_en) instr_count <= instr_count + CNT_W'(1);
                    // Halt waits until no control-flow change is pending this cycle.
                    if (halt_req && !flush) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then randomized traffic against a behavioural model.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b0, stall = 1'b0, fetch_ready = 1'b0, redirect_valid = 1'b0;
    logic        trap_valid = 1'b0, mret = 1'b0, halt_req = 1'b0;
    logic [31:0] redirect_target = '0;
`ifdef PC_GEN_COMPRESSED_EN
    logic        is_compressed = 1'b0;
`endif
    logic [31:0] pc_out, pc_plus4, epc_out, instr_count;
    logic        fetch_valid, misaligned, halted;

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .mret(mret), .halt_req(halt_req),
`ifdef PC_GEN_COMPRESSED_EN
        .is_compressed(is_compressed),
`endif
        .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .epc_out(epc_out),
        .misaligned(misaligned), .halted(halted), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cnt;
        logic        fv;
        logic        mis;
        logic        hlt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Behavioural model: phase 0 = booting, 1 = running, 2 = halted.
    logic [31:0] m_pc = '0, m_epc = '0, m_cnt = '0;
    logic        m_mis = 1'b0;
    int          m_phase = 0;

    task automatic model_step(input logic rst, st, rdy, rv, input logic [31:0] tgt,
                              input logic tr, mr, hr, cmp);
        logic acc, bad, trapped;
        longint unsigned stepv;
        if (!rst) begin
            m_pc = RV; m_epc = '0; m_cnt = '0; m_mis = 1'b0; m_phase = 0;
            return;
        end
        m_mis = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2) begin
            if (!hr) m_phase = 1;
        end else begin
            acc = rdy && !st;
`ifdef PC_GEN_COMPRESSED_EN
            bad   = (tgt % 2) != 0;
            stepv = cmp ? 2 : 4;
`else
            bad   = (tgt % 4) != 0;
            stepv = 4;
            if (cmp) stepv = 4;
`endif
            trapped = 1'b0;
            if (tr) begin
                m_epc = m_pc; m_pc = TV; trapped = 1'b1;
            end else if (mr) begin
                m_pc = m_epc;
            end else if (rv && bad) begin
                m_epc = m_pc; m_pc = TV; m_mis = 1'b1; trapped = 1'b1;
            end else if (rv) begin
                m_pc = tgt;
            end else if (acc) begin
                m_pc = 32'((64'(m_pc) + stepv) % 64'h1_0000_0000);
            end
            if (acc && !trapped) m_cnt = m_cnt + 1;
            if (hr && !(tr || mr || rv)) m_phase = 2;
        end
    endtask

    task automatic drive(input logic rst, st, rdy, rv, input logic [31:0] tgt,
                         input logic tr, mr, hr, cmp);
        exp_t e;
        @(negedge clock);
        reset = rst; stall = st; fetch_ready = rdy; redirect_valid = rv;
        redirect_target = tgt; trap_valid = tr; mret = mr; halt_req = hr;
`ifdef PC_GEN_COMPRESSED_EN
        is_compressed = cmp;
`endif
        model_step(rst, st, rdy, rv, tgt, tr, mr, hr, cmp);
        e.pc  = m_pc;  e.epc = m_epc; e.cnt = m_cnt;
        e.fv  = (m_phase == 1); e.mis = m_mis; e.hlt = (m_phase == 2);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    endtask

    // Monitor: every clock edge presents a new output set; compare it with the oldest expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_out",      pc_out,          e.pc);
            chk("pc_plus4",    pc_plus4,        e.pc + 32'd4);
            chk("epc_out",     epc_out,         e.epc);
            chk("instr_count", instr_count,     e.cnt);
            chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
            chk("misaligned",  32'(misaligned),  32'(e.mis));
            chk("halted",      32'(halted),      32'(e.hlt));
        end
    end

    initial begin
        logic [31:0] tgt;
        int          wait_cyc;
        // Reset, boot, sequential fetch.
        drive(0, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        idle(4);
        // Stall then redirect under stall.
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 32'h0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 32'h40, 0, 0, 0, 0);
        // Trap beats redirect, then mret.
        drive(1, 0, 1, 1, 32'h80, 1, 0, 0, 0);
        idle(2);
        drive(1, 0, 1, 0, 32'h0, 0, 1, 0, 0);
        idle(1);
        // Misaligned redirect from 0x20.
        drive(1, 0, 1, 1, 32'h20, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 32'h32, 0, 0, 0, 0);
        idle(2);
        drive(1, 0, 1, 1, 32'h33, 0, 0, 0, 0);
        idle(1);
        // Halt at 0x10 with an accept on the transition; trap ignored while halted.
        drive(1, 0, 1, 1, 32'h10, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 0, 1, 0);
        drive(1, 0, 1, 0, 32'h0, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 32'h44, 0, 1, 1, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        idle(2);
        // Halt request during a redirect is deferred.
        drive(1, 0, 1, 1, 32'h200, 0, 0, 1, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 0, 1, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        // Wrap at top of address space, then reset mid-run.
        drive(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 1, 1, 32'h80, 1, 0, 0, 0);
        idle(3);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clock);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
